// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier, 32x32 -> 64 (signed or unsigned operands).
// Latency: 17 CALC cycles after accept, or 1..17 with BOOTH_MUL_EARLY_EXIT_EN defined.
// Backpressure: holds result in DONE until out_ready; in_ready only in IDLE; cancel flushes.
//
// Ports:
//   clk, reset (async, active-high), cancel (flush, highest priority)
//   in_valid/in_ready, mul_signed, src1 (multiplicand X), src2 (multiplier Y)
//   out_valid/out_ready, result (64-bit product mod 2^64), busy (state != IDLE)
//
// Optional build macro: BOOTH_MUL_EARLY_EXIT_EN -- finish as soon as every
// remaining Booth digit is zero.

module booth_mul_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cancel,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mul_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [33:0] x34;
  logic [33:0] y34;
  logic [63:0] acc;
  logic [4:0]  cnt;

  // Multiplier with the implicit y[-1]=0 appended at bit 0, so group cnt
  // lives at bits [2*cnt+2 : 2*cnt].
  logic [34:0] yext;
  logic [5:0]  sh;
  logic [2:0]  grp;
  logic [33:0] x2;
  logic [33:0] pp34;
  logic        neg;
  logic [63:0] pp64;
  logic [63:0] acc_sum;
  logic        early_done;

  assign yext = {y34, 1'b0};
  assign sh   = {cnt, 1'b0};
  assign grp  = 3'(yext >> sh);
  // x34 is an extension of a 32-bit value, so 2X still fits in 34 bits.
  assign x2   = {x34[32:0], 1'b0};

  // Booth digit decode; negative digits are ~term with a +1 carry at the
  // digit's weight instead of a full two's-complement negate.
  always_comb begin
    pp34 = '0;
    neg  = 1'b0;
    case (grp)
      3'b001, 3'b010: pp34 = x34;
      3'b011:         pp34 = x2;
      3'b100: begin   pp34 = ~x2;  neg = 1'b1; end
      3'b101, 3'b110: begin pp34 = ~x34; neg = 1'b1; end
      default:        pp34 = '0;
    endcase
  end

  assign pp64    = {{30{pp34[33]}}, pp34};
  assign acc_sum = acc + (pp64 << sh) + (64'(neg) << sh);

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  // Remaining digits are all zero once y[33:2*cnt-1] is a run of equal bits.
  logic [34:0] y_rem;
  logic [34:0] ones_rem;
  assign y_rem      = yext >> sh;
  assign ones_rem   = {35{1'b1}} >> sh;
  assign early_done = (y_rem == '0) || (y_rem == ones_rem);
`else
  assign early_done = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (early_done || cnt == 5'd16) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cancel) state_nxt = IDLE;
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x34 <= '0;
      y34 <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (cancel) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x34 <= {{2{mul_signed & src1[31]}}, src1};
          y34 <= {{2{mul_signed & src2[31]}}, src2};
          acc <= '0;
          cnt <= '0;
        end
        CALC: if (!early_done) begin
          acc <= acc_sum;
          // Saturate at the last group rather than wrap.
          if (cnt != 5'd16) cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = (state == DONE) ? acc : 64'd0;

endmodule

// File: tb/tb_booth_mul_iter.sv
module tb_booth_mul_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cancel;
  logic        in_valid;
  logic        in_ready;
  logic        mul_signed;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_mul_iter dut (
    .clk(clk), .reset(reset), .cancel(cancel),
    .in_valid(in_valid), .in_ready(in_ready),
    .mul_signed(mul_signed), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mul_signed = s; src1 = a; src2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until out_valid, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ovld_fall"}, 64'(out_valid), 64'd0);
    chk({tag, "_irdy_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int lat);
    int cyc;
    issue(s, a, b);
    wait_done(cyc);
    chk({tag, "_result"}, result, exp);
    if (lat >= 0) chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    drain(tag);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [63:0] held;

    reset = 1'b1; cancel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mul_signed = 1'b0; src1 = '0; src2 = '0;
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_result",    result,         64'd0);
    @(negedge clk);
    reset = 1'b0;

`ifndef BOOTH_MUL_EARLY_EXIT_EN
    run("s_m1xm1",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 17);
    run("u_maxsq",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 17);
    run("s_minsq",   1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17);
    run("s_maxxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 17);
    run("u_maxx2",   1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 17);
    run("s_m3x5",    1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 17);

    // Busy during CALC, backpressure in DONE.
    issue(1'b0, 32'd6, 32'd7);
    chk("calc_busy",     64'(busy),     64'd1);
    chk("calc_in_ready", 64'(in_ready), 64'd0);
    wait_done(cyc);
    chk("bp_result", result, 64'd42);
    held = result;
    in_valid = 1'b1; src1 = 32'd1; src2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_result", result, held);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    drain("bp");
`else
    run("ee_y0",     1'b0, 32'd12345,     32'd0,        64'd0, 1);
    run("ee_7x3",    1'b0, 32'd7,         32'd3,        64'd21, -1);
    run("ee_neg",    1'b1, 32'd9,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7, -1);
    run("ee_minsq",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
    run("ee_umaxsq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 17);
`endif

    // Cancel with cnt=8 (8 edges after the accept edge).
    issue(1'b0, 32'd100, 32'd200);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_in_ready", 64'(in_ready), 64'd1);
    chk("cancel_busy",     64'(busy),     64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("cancel_no_out_valid", 64'(seen), 64'd0);
    run("after_cancel_3x5", 1'b0, 32'd3, 32'd5, 64'd15, -1);

    // Asynchronous reset mid-CALC.
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_busy",      64'(busy),      64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result",    result,         64'd0);
    @(negedge clk);
    reset = 1'b0;
    run("after_rst_3x5", 1'b0, 32'd3, 32'd5, 64'd15, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
